dcache_wb: RTL and testbench

//  Direct-mapped, write-back, write-allocate data cache between the execute-stage

---
 rtl/dcache_wb.sv | 181 ++++++++++++++++++
 tb/tb_dcache_wb.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache with 4-word lines.
// Hits are serviced combinationally; misses run a write-back/refill FSM over a req/ack port.
module dcache_wb #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_BITS   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_en,
  input  logic                    wr_en,
  input  logic [31:0]             addr,
  input  logic [DATA_WIDTH-1:0]   WriteData,
  input  logic [2:0]              funct3,
  output logic [DATA_WIDTH-1:0]   ReadData,
  output logic                    stall,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [31:0]             mem_addr,
  output logic [4*DATA_WIDTH-1:0] mem_wdata,
  input  logic [4*DATA_WIDTH-1:0] mem_rdata,
  input  logic                    mem_ack
);

  localparam int LINES = 1 << IDX_BITS;
  localparam int TAG_W = 32 - IDX_BITS - 4;
  localparam int BYTES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, WB, REFILL, DONE} state_t;

  state_t state_reg, state_next;

  logic [LINES-1:0]                 valid_reg;
  logic [LINES-1:0]                 dirty_reg;
  logic [TAG_W-1:0]                 tag_reg  [LINES];
  logic [3:0][DATA_WIDTH-1:0]       data_reg [LINES];

  logic [TAG_W-1:0]    miss_tag_reg;
  logic [IDX_BITS-1:0] miss_idx_reg;
  logic                miss_capture;

  logic [TAG_W-1:0]    req_tag;
  logic [IDX_BITS-1:0] req_idx;
  logic [1:0]          word_sel;
  logic                req;
  logic                hit;
  logic                store_hit;
  logic                refill_done;

  logic [DATA_WIDTH-1:0]            cur_word;
  logic [BYTES-1:0][7:0]            word_bytes;
  logic [DATA_WIDTH/16-1:0][15:0]   word_halves;
  logic [7:0]                       byte_val;
  logic [15:0]                      half_val;

  logic [BYTES-1:0]      byte_en;
  logic [DATA_WIDTH-1:0] store_lanes;
  logic [DATA_WIDTH-1:0] merged_word;

  assign req_tag  = addr[31:IDX_BITS+4];
  assign req_idx  = addr[IDX_BITS+3:4];
  assign word_sel = addr[3:2];
  assign req      = rd_en | wr_en;
  assign hit      = req & valid_reg[req_idx] & (tag_reg[req_idx] == req_tag);

  assign store_hit   = wr_en & hit & (state_reg == IDLE);
  assign refill_done = (state_reg == REFILL) & mem_ack;

  assign cur_word    = data_reg[req_idx][word_sel];
  assign word_bytes  = cur_word;
  assign word_halves = cur_word;
  assign byte_val    = word_bytes[addr[1:0]];
  assign half_val    = word_halves[addr[1]];

  always_comb begin
    ReadData = '0;
    if (rd_en && !wr_en && hit) begin
      case (funct3)
        3'b000:  ReadData = {{(DATA_WIDTH-8){byte_val[7]}}, byte_val};
        3'b001:  ReadData = {{(DATA_WIDTH-16){half_val[15]}}, half_val};
        3'b100:  ReadData = {{(DATA_WIDTH-8){1'b0}}, byte_val};
        3'b101:  ReadData = {{(DATA_WIDTH-16){1'b0}}, half_val};
        default: ReadData = cur_word;
      endcase
    end
  end

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    byte_en     = '1;
    store_lanes = WriteData;
    case (funct3[1:0])
      2'b00: begin
        byte_en     = BYTES'(1) << addr[1:0];
        store_lanes = {BYTES{WriteData[7:0]}};
      end
      2'b01: begin
        byte_en     = BYTES'(2'b11) << {addr[1], 1'b0};
        store_lanes = {(BYTES/2){WriteData[15:0]}};
      end
      default: begin
        byte_en     = '1;
        store_lanes = WriteData;
      end
    endcase
  end

  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_merge
      assign merged_word[gi*8 +: 8] = byte_en[gi] ? store_lanes[gi*8 +: 8] : cur_word[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    miss_capture = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    case (state_reg)
      IDLE: begin
        if (req && !hit) begin
          miss_capture = 1'b1;
          state_next   = (valid_reg[req_idx] && dirty_reg[req_idx]) ? WB : REFILL;
        end
      end
      WB: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {tag_reg[miss_idx_reg], miss_idx_reg, 4'b0000};
        if (mem_ack) state_next = REFILL;
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {miss_tag_reg, miss_idx_reg, 4'b0000};
        if (mem_ack) state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign mem_wdata = data_reg[miss_idx_reg];
  assign stall     = (req & ~hit) | (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      miss_tag_reg <= '0;
      miss_idx_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (miss_capture) begin
        miss_tag_reg <= req_tag;
        miss_idx_reg <= req_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
      dirty_reg <= '0;
    end else if (refill_done) begin
      valid_reg[miss_idx_reg] <= 1'b1;
      dirty_reg[miss_idx_reg] <= 1'b0;
    end else if (store_hit) begin
      dirty_reg[req_idx] <= 1'b1;
    end
  end

  // Tag/data storage carries no reset; the valid bits alone qualify it.
  always_ff @(posedge clk) begin
    if (!rst && refill_done) begin
      data_reg[miss_idx_reg] <= mem_rdata;
      tag_reg[miss_idx_reg]  <= miss_tag_reg;
    end else if (!rst && store_hit) begin
      data_reg[req_idx][word_sel] <= merged_word;
    end
  end

endmodule

// File: tb/tb_dcache_wb.sv
// Directed testbench for dcache_wb: hand-computed loads, stores, write-back and refill traffic.
module tb_dcache_wb;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd_en;
  logic         wr_en;
  logic [31:0]  addr;
  logic [31:0]  WriteData;
  logic [2:0]   funct3;
  logic [31:0]  ReadData;
  logic         stall;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ack;

  int n_cmp = 0;
  int n_bad = 0;

  dcache_wb #(.DATA_WIDTH(32), .IDX_BITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .addr      (addr),
    .WriteData (WriteData),
    .funct3    (funct3),
    .ReadData  (ReadData),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] f);
    rd_en  = 1'b1;
    wr_en  = 1'b0;
    addr   = a;
    funct3 = f;
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
    rd_en     = 1'b0;
    wr_en     = 1'b1;
    addr      = a;
    funct3    = f;
    WriteData = d;
    #1;
  endtask

  task automatic idle_req();
    rd_en = 1'b0;
    wr_en = 1'b0;
    #1;
  endtask

  logic [127:0] line_a;
  logic [127:0] line_a_dirty;
  logic [127:0] line_b;
  logic [127:0] line_st;

  initial begin
    line_a       = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
    line_a_dirty = {32'hCAFEF00D, 32'hABCD2222, 32'h11111111, 32'hDEAD12EF};
    line_b       = {32'h53535353, 32'h52525252, 32'h51515151, 32'h50505050};
    line_st      = {32'h0, 32'h0, 32'h87654321, 32'h0};

    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = '0; WriteData = '0;
    funct3 = 3'b010; mem_rdata = '0; mem_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check_eq("reset_stall", stall, 1'b0);
    check_eq("reset_req", mem_req, 1'b0);
    check_eq("reset_we", mem_we, 1'b0);
    check_eq("reset_rdata", ReadData, 32'h0);

    // Clean miss on 0x100: IDLE -> REFILL -> DONE -> hit
    load(32'h100, 3'b010);
    check_eq("t1_miss_stall", stall, 1'b1);
    check_eq("t1_miss_rdata", ReadData, 32'h0);
    tick();
    check_eq("t1_refill_req", mem_req, 1'b1);
    check_eq("t1_refill_we", mem_we, 1'b0);
    check_eq("t1_refill_addr", mem_addr, 32'h100);
    mem_ack = 1'b1; mem_rdata = line_a;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    #1;
    check_eq("t1_done_stall", stall, 1'b1);
    check_eq("t1_done_req", mem_req, 1'b0);
    tick();
    check_eq("t1_hit_stall", stall, 1'b0);
    check_eq("t1_hit_lw", ReadData, 32'hDEADBEEF);

    // Sub-word load extension
    load(32'h103, 3'b000); check_eq("t2_lb", ReadData, 32'hFFFFFFDE);
    load(32'h103, 3'b100); check_eq("t2_lbu", ReadData, 32'h000000DE);
    load(32'h102, 3'b001); check_eq("t2_lh", ReadData, 32'hFFFFDEAD);
    load(32'h100, 3'b101); check_eq("t2_lhu", ReadData, 32'h0000BEEF);
    load(32'h101, 3'b001); check_eq("t2_lh_misalign", ReadData, 32'hFFFFBEEF);
    load(32'h104, 3'b010); check_eq("t2_lw_word1", ReadData, 32'h11111111);
    check_eq("t2_stall", stall, 1'b0);

    // Store hits: SB, SH upper half, misaligned SW
    store(32'h101, 3'b000, 32'hFFFFFF12);
    check_eq("t3_sb_stall", stall, 1'b0);
    tick();
    store(32'h10A, 3'b001, 32'h0000ABCD);
    tick();
    store(32'h10F, 3'b010, 32'hCAFEF00D);
    tick();
    load(32'h100, 3'b010);
    check_eq("t3_lw_after_sb", ReadData, 32'hDEAD12EF);
    check_eq("t3_stall", stall, 1'b0);
    load(32'h108, 3'b010); check_eq("t3_lw_after_sh", ReadData, 32'hABCD2222);
    load(32'h10C, 3'b010); check_eq("t3_lw_after_sw", ReadData, 32'hCAFEF00D);

    // Dirty miss on 0x500 with ack held off for 3 cycles in each phase
    load(32'h500, 3'b010);
    check_eq("t4_miss_stall", stall, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("t4_wb_req_%0d", i), mem_req, 1'b1);
      check_eq($sformatf("t4_wb_we_%0d", i), mem_we, 1'b1);
      check_eq($sformatf("t4_wb_addr_%0d", i), mem_addr, 32'h100);
      check_eq($sformatf("t4_wb_wdata_%0d", i), mem_wdata, line_a_dirty);
      tick();
    end
    check_eq("t4_wb_addr_ack", mem_addr, 32'h100);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("t4_rf_req_%0d", i), mem_req, 1'b1);
      check_eq($sformatf("t4_rf_we_%0d", i), mem_we, 1'b0);
      check_eq($sformatf("t4_rf_addr_%0d", i), mem_addr, 32'h500);
      tick();
    end
    mem_ack = 1'b1; mem_rdata = line_b;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    #1;
    check_eq("t4_done_stall", stall, 1'b1);
    check_eq("t4_done_req", mem_req, 1'b0);
    tick();
    check_eq("t4_hit_stall", stall, 1'b0);
    check_eq("t4_hit_lw", ReadData, 32'h50505050);

    // Clean victim: refill directly, no write-back phase
    load(32'h10C, 3'b010);
    check_eq("t5_miss_stall", stall, 1'b1);
    tick();
    check_eq("t5_req", mem_req, 1'b1);
    check_eq("t5_we", mem_we, 1'b0);
    check_eq("t5_addr", mem_addr, 32'h100);
    mem_ack = 1'b1; mem_rdata = line_a_dirty;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    tick();
    check_eq("t5_hit_lw", ReadData, 32'hCAFEF00D);

    // Store miss: allocate, merge on the hit cycle, then evict the dirty line
    store(32'h214, 3'b010, 32'h87654321);
    check_eq("t5s_miss_stall", stall, 1'b1);
    tick();
    check_eq("t5s_refill_addr", mem_addr, 32'h210);
    mem_ack = 1'b1; mem_rdata = '0;
    tick();
    mem_ack = 1'b0;
    tick();
    check_eq("t5s_hit_stall", stall, 1'b0);
    tick();
    load(32'h214, 3'b010);
    check_eq("t5s_lw", ReadData, 32'h87654321);
    load(32'h310, 3'b010);
    tick();
    check_eq("t5s_wb_we", mem_we, 1'b1);
    check_eq("t5s_wb_addr", mem_addr, 32'h210);
    check_eq("t5s_wb_wdata", mem_wdata, line_st);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    #1;
    check_eq("t6_refill_addr", mem_addr, 32'h310);

    // Reset mid-REFILL abandons the transfer and invalidates every line
    rst = 1'b1;
    idle_req();
    tick();
    rst = 1'b0;
    #1;
    check_eq("t6_req_after_rst", mem_req, 1'b0);
    check_eq("t6_stall_after_rst", stall, 1'b0);
    load(32'h500, 3'b010);
    check_eq("t6_lw500_misses", stall, 1'b1);
    tick();
    check_eq("t6_refill_no_wb", mem_we, 1'b0);
    check_eq("t6_refill_addr500", mem_addr, 32'h500);
    mem_ack = 1'b1; mem_rdata = line_b;
    tick();
    mem_ack = 1'b0;
    idle_req();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
